// File: rtl/minisys_id.sv
// MiniSys instruction-decode stage: register file with write-through bypass,
// MIPS-subset decoder, jump resolution, load-use detection and the ID/EX register.
module minisys_id #(
    parameter int RA_REG = 31
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] instrD,
    input  logic [31:0] pcplus4D,
    input  logic        regwriteW,
    input  logic [4:0]  writeregW,
    input  logic [31:0] resultW,
    input  logic        flushE,
    input  logic        keepmdE,
    output logic        load_use,
    output logic        jumpI,
    output logic [31:0] pc_jumpI,
    output logic [31:0] pcplus4E,
    output logic [31:0] rdata1E,
    output logic [31:0] rdata2E,
    output logic [31:0] immE,
    output logic [4:0]  shamtE,
    output logic [4:0]  rsE,
    output logic [4:0]  rtE,
    output logic [4:0]  rdE,
    output logic [3:0]  aluctrlE,
    output logic        alusrcE,
    output logic        regwriteE,
    output logic        memtoregE,
    output logic        memwriteE,
    output logic        memreadE,
    output logic        branchE,
    output logic        bneE,
    output logic        linkE,
    output logic [1:0]  regdstE
);

    localparam logic [1:0] IMM_SIGN = 2'd0;
    localparam logic [1:0] IMM_ZERO = 2'd1;
    localparam logic [1:0] IMM_LUI  = 2'd2;

    typedef struct packed {
        logic [31:0] pcplus4;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [3:0]  aluctrl;
        logic        alusrc;
        logic        regwrite;
        logic        memtoreg;
        logic        memwrite;
        logic        memread;
        logic        branch;
        logic        bne;
        logic        link;
        logic [1:0]  regdst;
    } idex_t;

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
    logic [15:0] w_imm16;
    logic [31:0] w_rdata1, w_rdata2, w_imm;
    logic [31:0] r_regs [32];
    logic [3:0]  w_ralu, w_alu;
    logic        w_rvalid, w_shift;
    logic        w_alusrc, w_regwrite, w_memtoreg, w_memwrite, w_memread;
    logic        w_branch, w_bne, w_link, w_use_rs, w_use_rt, w_jump, w_jr;
    logic [1:0]  w_regdst, w_immsel;
    logic        w_load_use;
    idex_t       w_dec, r_ex;

    assign w_op    = instrD[31:26];
    assign w_rs    = instrD[25:21];
    assign w_rt    = instrD[20:16];
    assign w_rd    = instrD[15:11];
    assign w_shamt = instrD[10:6];
    assign w_funct = instrD[5:0];
    assign w_imm16 = instrD[15:0];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (regwriteW && writeregW != 5'd0) begin
            r_regs[writeregW] <= resultW;
        end
    end

    // Same-cycle writeback is forwarded so decode never sees a stale value.
    assign w_rdata1 = (w_rs == 5'd0) ? '0 :
                      (regwriteW && writeregW == w_rs) ? resultW : r_regs[w_rs];
    assign w_rdata2 = (w_rt == 5'd0) ? '0 :
                      (regwriteW && writeregW == w_rt) ? resultW : r_regs[w_rt];

    assign w_shift = (w_funct[5:2] == 4'b0000);

    always_comb begin
        w_ralu   = 4'h0;
        w_rvalid = 1'b1;
        case (w_funct)
            6'h20, 6'h21: w_ralu = 4'h0;
            6'h22, 6'h23: w_ralu = 4'h1;
            6'h24:        w_ralu = 4'h2;
            6'h25:        w_ralu = 4'h3;
            6'h26:        w_ralu = 4'h4;
            6'h27:        w_ralu = 4'h5;
            6'h2A:        w_ralu = 4'h6;
            6'h2B:        w_ralu = 4'h7;
            6'h00:        w_ralu = 4'h8;
            6'h02:        w_ralu = 4'h9;
            6'h03:        w_ralu = 4'hA;
            default:      w_rvalid = 1'b0;
        endcase
    end

    always_comb begin
        w_alu      = 4'h0;
        w_alusrc   = 1'b0;
        w_regwrite = 1'b0;
        w_memtoreg = 1'b0;
        w_memwrite = 1'b0;
        w_memread  = 1'b0;
        w_branch   = 1'b0;
        w_bne      = 1'b0;
        w_link     = 1'b0;
        w_regdst   = 2'd0;
        w_immsel   = IMM_SIGN;
        w_use_rs   = 1'b0;
        w_use_rt   = 1'b0;
        w_jump     = 1'b0;
        w_jr       = 1'b0;
        case (w_op)
            6'h00: begin
                if (w_funct == 6'h08) begin
                    w_jump   = 1'b1;
                    w_jr     = 1'b1;
                    w_use_rs = 1'b1;
                end else if (w_rvalid) begin
                    w_alu      = w_ralu;
                    w_regwrite = 1'b1;
                    w_regdst   = 2'd1;
                    w_use_rt   = 1'b1;
                    w_use_rs   = !w_shift;
                end
            end
            6'h02: w_jump = 1'b1;
            6'h03: begin
                w_jump     = 1'b1;
                w_link     = 1'b1;
                w_regwrite = 1'b1;
                w_regdst   = 2'd2;
            end
            6'h04, 6'h05: begin
                w_alu    = 4'h1;
                w_branch = 1'b1;
                w_bne    = w_op[0];
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
                w_use_rs   = 1'b1;
                case (w_op[2:0])
                    3'd2:    w_alu = 4'h6;
                    3'd3:    w_alu = 4'h7;
                    3'd4:    begin w_alu = 4'h2; w_immsel = IMM_ZERO; end
                    3'd5:    begin w_alu = 4'h3; w_immsel = IMM_ZERO; end
                    3'd6:    begin w_alu = 4'h4; w_immsel = IMM_ZERO; end
                    default: w_alu = 4'h0;
                endcase
            end
            6'h0F: begin
                w_alu      = 4'hB;
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
                w_immsel   = IMM_LUI;
            end
            6'h23: begin
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
                w_memread  = 1'b1;
                w_use_rs   = 1'b1;
            end
            6'h2B: begin
                w_alusrc   = 1'b1;
                w_memwrite = 1'b1;
                w_use_rs   = 1'b1;
                w_use_rt   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (w_immsel)
            IMM_ZERO: w_imm = {16'h0000, w_imm16};
            IMM_LUI:  w_imm = {w_imm16, 16'h0000};
            default:  w_imm = {{16{w_imm16[15]}}, w_imm16};
        endcase
    end

    always_comb begin
        w_dec.pcplus4  = pcplus4D;
        w_dec.rdata1   = w_rdata1;
        w_dec.rdata2   = w_rdata2;
        w_dec.imm      = w_imm;
        w_dec.shamt    = w_shamt;
        w_dec.rs       = w_rs;
        w_dec.rt       = w_rt;
        // jal has no rd field; carry the link register index instead of target bits.
        w_dec.rd       = w_link ? 5'(RA_REG) : w_rd;
        w_dec.aluctrl  = w_alu;
        w_dec.alusrc   = w_alusrc;
        w_dec.regwrite = w_regwrite;
        w_dec.memtoreg = w_memtoreg;
        w_dec.memwrite = w_memwrite;
        w_dec.memread  = w_memread;
        w_dec.branch   = w_branch;
        w_dec.bne      = w_bne;
        w_dec.link     = w_link;
        w_dec.regdst   = w_regdst;
    end

    assign w_load_use = r_ex.memread && (r_ex.rt != 5'd0) &&
                        ((w_use_rs && r_ex.rt == w_rs) || (w_use_rt && r_ex.rt == w_rt));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_ex <= '0;
        end else if (flushE || (!keepmdE && w_load_use)) begin
            r_ex <= '0;
        end else if (!keepmdE) begin
            r_ex <= w_dec;
        end
    end

    assign load_use  = w_load_use;
    assign jumpI     = w_jump && !w_load_use && !keepmdE;
    assign pc_jumpI  = !w_jump ? '0 :
                       w_jr    ? w_rdata1 : {pcplus4D[31:28], instrD[25:0], 2'b00};

    assign pcplus4E  = r_ex.pcplus4;
    assign rdata1E   = r_ex.rdata1;
    assign rdata2E   = r_ex.rdata2;
    assign immE      = r_ex.imm;
    assign shamtE    = r_ex.shamt;
    assign rsE       = r_ex.rs;
    assign rtE       = r_ex.rt;
    assign rdE       = r_ex.rd;
    assign aluctrlE  = r_ex.aluctrl;
    assign alusrcE   = r_ex.alusrc;
    assign regwriteE = r_ex.regwrite;
    assign memtoregE = r_ex.memtoreg;
    assign memwriteE = r_ex.memwrite;
    assign memreadE  = r_ex.memread;
    assign branchE   = r_ex.branch;
    assign bneE      = r_ex.bne;
    assign linkE     = r_ex.link;
    assign regdstE   = r_ex.regdst;

endmodule

// File: tb/tb_minisys_id.sv
// Scoreboard bench for minisys_id: expected ID/EX contents are queued when an
// instruction is presented and checked one cycle later.
module tb_minisys_id;

    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] instrD, pcplus4D, resultW;
    logic        regwriteW, flushE, keepmdE;
    logic [4:0]  writeregW;
    logic        load_use, jumpI;
    logic [31:0] pc_jumpI, pcplus4E, rdata1E, rdata2E, immE;
    logic [4:0]  shamtE, rsE, rtE, rdE;
    logic [3:0]  aluctrlE;
    logic        alusrcE, regwriteE, memtoregE, memwriteE, memreadE, branchE, bneE, linkE;
    logic [1:0]  regdstE;

    minisys_id #(.RA_REG(31)) dut (
        .clk(clk), .clrn(clrn), .instrD(instrD), .pcplus4D(pcplus4D),
        .regwriteW(regwriteW), .writeregW(writeregW), .resultW(resultW),
        .flushE(flushE), .keepmdE(keepmdE), .load_use(load_use), .jumpI(jumpI),
        .pc_jumpI(pc_jumpI), .pcplus4E(pcplus4E), .rdata1E(rdata1E), .rdata2E(rdata2E),
        .immE(immE), .shamtE(shamtE), .rsE(rsE), .rtE(rtE), .rdE(rdE),
        .aluctrlE(aluctrlE), .alusrcE(alusrcE), .regwriteE(regwriteE),
        .memtoregE(memtoregE), .memwriteE(memwriteE), .memreadE(memreadE),
        .branchE(branchE), .bneE(bneE), .linkE(linkE), .regdstE(regdstE)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [45:0] c;
        logic        chkd;
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    logic [45:0]  act_c;
    logic [161:0] all_e;
    assign act_c = {aluctrlE, alusrcE, regwriteE, memtoregE, memwriteE, memreadE,
                    branchE, bneE, linkE, regdstE, immE};
    assign all_e = {pcplus4E, rdata1E, rdata2E, immE, shamtE, rsE, rtE, rdE, aluctrlE,
                    alusrcE, regwriteE, memtoregE, memwriteE, memreadE, branchE, bneE,
                    linkE, regdstE};

    // Flag order: {alusrc, regwrite, memtoreg, memwrite, memread, branch, bne, link}
    function automatic logic [13:0] c(input logic [3:0] alu, input logic [7:0] f,
                                      input logic [1:0] rd);
        return {alu, f, rd};
    endfunction

    localparam logic [7:0] F_R  = 8'b0100_0000;
    localparam logic [7:0] F_I  = 8'b1100_0000;
    localparam logic [7:0] F_LW = 8'b1110_1000;

    task automatic push(input string nm, input logic [13:0] ctl, input logic [31:0] imm,
                        input logic chkd, input logic [31:0] d1, input logic [31:0] d2);
        exp_t x;
        x.nm = nm; x.c = {ctl, imm}; x.chkd = chkd; x.d1 = d1; x.d2 = d2;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clrn = 1'b0; instrD = '0; pcplus4D = '0; regwriteW = 1'b0; writeregW = '0;
        resultW = '0; flushE = 1'b0; keepmdE = 1'b0;
        tick(); tick();
        total++;
        if ({all_e, load_use, jumpI} !== '0) begin
            bad++; $display("FAIL reset_init act=%h req=0", {all_e, load_use, jumpI});
        end
        clrn = 1'b1;
        regwriteW = 1'b1; writeregW = 5'd5; resultW = 32'hDEADBEEF;
        instrD = 32'h8C280000;
        push("lw_pre", c(4'h0, F_LW, 2'd0), 32'h0, 1'b0, '0, '0);
        tick();
        regwriteW = 1'b0;
        e = sb.pop_front(); total++;
        $display("txn %s ctl=%h", e.nm, act_c);
        if (act_c !== e.c) begin bad++; $display("FAIL %s ctl act=%h req=%h", e.nm, act_c, e.c); end
        instrD = 32'h01024820;
        #1;
        total++;
        if (load_use !== 1'b1) begin bad++; $display("FAIL pre_reset_lu act=%b req=1", load_use); end
        #2;
        clrn = 1'b0; instrD = '0;
        #1;
        total++;
        if ({all_e, load_use, jumpI} !== '0) begin
            bad++; $display("FAIL reset_mid act=%h req=0", {all_e, load_use, jumpI});
        end
        tick();
        clrn = 1'b1;
        instrD = 32'h00A53020;
        push("rd5_after_rst", c(4'h0, F_R, 2'd1), 32'h3020, 1'b1, 32'h0, 32'h0);
        tick();
        e = sb.pop_front(); total++;
        $display("txn %s ctl=%h", e.nm, act_c);
        if (act_c !== e.c) begin bad++; $display("FAIL %s ctl act=%h req=%h", e.nm, act_c, e.c); end
        total++;
        if ({rdata1E, rdata2E} !== {e.d1, e.d2}) begin
            bad++; $display("FAIL %s data act=%h req=%h", e.nm, {rdata1E, rdata2E}, {e.d1, e.d2});
        end
    endtask

    task automatic test_bypass();
        logic [31:0] iv [3] = '{32'h00632020, 32'h00000820, 32'h00602020};
        logic [31:0] ev [3] = '{32'h00002020, 32'h00000820, 32'h00002020};
        logic [4:0]  wr [3] = '{5'd3, 5'd0, 5'd0};
        logic        we [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] d1 [3] = '{32'h12345678, 32'h0, 32'h12345678};
        logic [31:0] d2 [3] = '{32'h12345678, 32'h0, 32'h0};
        string       nv [3] = '{"bypass_r3", "write_r0", "stored_r3"};
        for (int i = 0; i < 3; i++) begin
            regwriteW = we[i]; writeregW = wr[i];
            resultW = (i == 0) ? 32'h12345678 : 32'hFFFFFFFF;
            instrD = iv[i];
            push(nv[i], c(4'h0, F_R, 2'd1), ev[i], 1'b1, d1[i], d2[i]);
            tick();
            e = sb.pop_front(); total++;
            $display("txn %s ctl=%h d=%h", e.nm, act_c, {rdata1E, rdata2E});
            if (act_c !== e.c) begin bad++; $display("FAIL %s ctl act=%h req=%h", e.nm, act_c, e.c); end
            total++;
            if ({rdata1E, rdata2E} !== {e.d1, e.d2}) begin
                bad++; $display("FAIL %s data act=%h req=%h", e.nm, {rdata1E, rdata2E}, {e.d1, e.d2});
            end
        end
        regwriteW = 1'b0; writeregW = '0;
        total++;
        if ({rsE, rtE, rdE} !== {5'd3, 5'd0, 5'd4}) begin
            bad++; $display("FAIL fields act=%h req=%h", {rsE, rtE, rdE}, {5'd3, 5'd0, 5'd4});
        end
    endtask

    task automatic test_load_use();
        // Each step: instruction, expected load_use while in D, expected E contents after.
        logic [31:0] iv [7] = '{32'h8C280000, 32'h01024820, 32'h01024820, 32'h8C200000,
                                32'h00004900, 32'h8C280000, 32'h3C081234};
        logic        lu [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [13:0] cv [7];
        logic [31:0] mv [7] = '{32'h0, 32'h0, 32'h4820, 32'h0, 32'h4900, 32'h0, 32'h12340000};
        string       nv [7] = '{"lw_r8", "lu_bubble", "add_after", "lw_r0", "sll_rt0",
                                "lw_r8b", "lui_r8"};
        cv = '{c(4'h0, F_LW, 2'd0), 14'h0, c(4'h0, F_R, 2'd1), c(4'h0, F_LW, 2'd0),
               c(4'h8, F_R, 2'd1), c(4'h0, F_LW, 2'd0), c(4'hB, F_I, 2'd0)};
        for (int i = 0; i < 7; i++) begin
            instrD = iv[i];
            if (i == 6) begin
                instrD = 32'h00084880;
                #1;
                total++;
                if (load_use !== 1'b1) begin bad++; $display("FAIL lu_sll_rt8 act=%b req=1", load_use); end
                instrD = iv[i];
            end
            #1;
            total++;
            if (load_use !== lu[i]) begin bad++; $display("FAIL %s_lu act=%b req=%b", nv[i], load_use, lu[i]); end
            push(nv[i], cv[i], mv[i], 1'b0, '0, '0);
            tick();
            e = sb.pop_front(); total++;
            $display("txn %s ctl=%h", e.nm, act_c);
            if (act_c !== e.c) begin bad++; $display("FAIL %s ctl act=%h req=%h", e.nm, act_c, e.c); end
        end
    endtask

    task automatic test_jump();
        pcplus4D = 32'h00400004;
        instrD = 32'h08040010;
        #1;
        total++;
        if ({jumpI, pc_jumpI} !== {1'b1, 32'h00100040}) begin
            bad++; $display("FAIL j_target act=%h req=%h", {jumpI, pc_jumpI}, {1'b1, 32'h00100040});
        end
        push("j", 14'h0, 32'h10, 1'b0, '0, '0);
        tick();
        e = sb.pop_front(); total++;
        $display("txn %s ctl=%h", e.nm, act_c);
        if (act_c !== e.c) begin bad++; $display("FAIL %s ctl act=%h req=%h", e.nm, act_c, e.c); end
        instrD = 32'h0C040010;
        #1;
        total++;
        if ({jumpI, pc_jumpI} !== {1'b1, 32'h00100040}) begin
            bad++; $display("FAIL jal_target act=%h req=%h", {jumpI, pc_jumpI}, {1'b1, 32'h00100040});
        end
        push("jal", c(4'h0, 8'b0100_0001, 2'd2), 32'h10, 1'b0, '0, '0);
        tick();
        e = sb.pop_front(); total++;
        $display("txn %s ctl=%h", e.nm, act_c);
        if (act_c !== e.c) begin bad++; $display("FAIL %s ctl act=%h req=%h", e.nm, act_c, e.c); end
        total++;
        if (pcplus4E !== 32'h00400004) begin bad++; $display("FAIL jal_pc4 act=%h req=00400004", pcplus4E); end
        regwriteW = 1'b1; writeregW = 5'd31; resultW = 32'h00400020;
        instrD = 32'h03E00008;
        #1;
        total++;
        if ({jumpI, pc_jumpI} !== {1'b1, 32'h00400020}) begin
            bad++; $display("FAIL jr_target act=%h req=%h", {jumpI, pc_jumpI}, {1'b1, 32'h00400020});
        end
        push("jr", 14'h0, 32'h8, 1'b1, 32'h00400020, 32'h0);
        tick();
        regwriteW = 1'b0;
        e = sb.pop_front(); total++;
        $display("txn %s ctl=%h d=%h", e.nm, act_c, {rdata1E, rdata2E});
        if (act_c !== e.c) begin bad++; $display("FAIL %s ctl act=%h req=%h", e.nm, act_c, e.c); end
        total++;
        if ({rdata1E, rdata2E} !== {e.d1, e.d2}) begin
            bad++; $display("FAIL %s data act=%h req=%h", e.nm, {rdata1E, rdata2E}, {e.d1, e.d2});
        end
        instrD = 32'h00632020;
        #1;
        total++;
        if ({jumpI, pc_jumpI} !== 33'h0) begin bad++; $display("FAIL nojump act=%h req=0", {jumpI, pc_jumpI}); end
    endtask

    task automatic test_keep();
        logic [31:0] iv [3] = '{32'h08040010, 32'h3402FFFF, 32'h8C280000};
        instrD = 32'h00632020;
        push("keep_load", c(4'h0, F_R, 2'd1), 32'h2020, 1'b1, 32'h12345678, 32'h12345678);
        tick();
        e = sb.pop_front(); total++;
        $display("txn %s ctl=%h", e.nm, act_c);
        if (act_c !== e.c) begin bad++; $display("FAIL %s ctl act=%h req=%h", e.nm, act_c, e.c); end
        keepmdE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instrD = iv[i];
            #1;
            total++;
            if (jumpI !== 1'b0) begin bad++; $display("FAIL keep_jump%0d act=%b req=0", i, jumpI); end
            push("keep_hold", c(4'h0, F_R, 2'd1), 32'h2020, 1'b1, 32'h12345678, 32'h12345678);
            tick();
            e = sb.pop_front(); total++;
            $display("txn %s ctl=%h d=%h", e.nm, act_c, {rdata1E, rdata2E});
            if (act_c !== e.c) begin bad++; $display("FAIL %s ctl act=%h req=%h", e.nm, act_c, e.c); end
            total++;
            if ({rdata1E, rdata2E} !== {e.d1, e.d2}) begin
                bad++; $display("FAIL %s data act=%h req=%h", e.nm, {rdata1E, rdata2E}, {e.d1, e.d2});
            end
        end
        flushE = 1'b1;
        push("flush_keep", 14'h0, 32'h0, 1'b1, 32'h0, 32'h0);
        tick();
        flushE = 1'b0; keepmdE = 1'b0;
        e = sb.pop_front(); total++;
        $display("txn %s ctl=%h", e.nm, act_c);
        if (act_c !== e.c) begin bad++; $display("FAIL %s ctl act=%h req=%h", e.nm, act_c, e.c); end
        total++;
        if ({rdata1E, rdata2E} !== {e.d1, e.d2}) begin
            bad++; $display("FAIL %s data act=%h req=%h", e.nm, {rdata1E, rdata2E}, {e.d1, e.d2});
        end
    endtask

    task automatic test_imm();
        logic [31:0] iv [10] = '{32'h3402FFFF, 32'h2002FFFF, 32'h30428000, 32'h2842FFFE,
                                 32'h3C021234, 32'hAC250004, 32'h1022FFFF, 32'h1422FFFF,
                                 32'hFC000000, 32'h000218C3};
        logic [31:0] mv [10] = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h00008000, 32'hFFFFFFFE,
                                 32'h12340000, 32'h00000004, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'h0, 32'h000018C3};
        string nv [10] = '{"ori", "addi", "andi", "slti", "lui", "sw", "beq", "bne",
                           "undef", "sra"};
        logic [13:0] cv [10];
        cv = '{c(4'h3, F_I, 2'd0), c(4'h0, F_I, 2'd0), c(4'h2, F_I, 2'd0),
               c(4'h6, F_I, 2'd0), c(4'hB, F_I, 2'd0), c(4'h0, 8'b1001_0000, 2'd0),
               c(4'h1, 8'b0000_0100, 2'd0), c(4'h1, 8'b0000_0110, 2'd0), 14'h0,
               c(4'hA, F_R, 2'd1)};
        for (int i = 0; i < 10; i++) begin
            instrD = iv[i];
            push(nv[i], cv[i], mv[i], 1'b0, '0, '0);
            tick();
            e = sb.pop_front(); total++;
            $display("txn %s ctl=%h", e.nm, act_c);
            if (act_c !== e.c) begin bad++; $display("FAIL %s ctl act=%h req=%h", e.nm, act_c, e.c); end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_load_use();
        test_jump();
        test_keep();
        test_imm();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
